window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/win_pkg.sv | 23 ++
 rtl/window_3x3_gen_line_buffer.sv | 24 ++
 rtl/window_3x3_gen.sv | 142 ++++++++++++++
 tb/tb_window_3x3_gen.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/win_pkg.sv
// Shared types for the 3x3 window generator: frame FSM states and the
// row-major positions of the nine window taps.
package win_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam int W_TL  = 0;
    localparam int W_TM  = 1;
    localparam int W_TR  = 2;
    localparam int W_ML  = 3;
    localparam int W_MM  = 4;
    localparam int W_MR  = 5;
    localparam int W_BL  = 6;
    localparam int W_BM  = 7;
    localparam int W_BR  = 8;
    localparam int WIN_N = 9;

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One row of pixel storage. The read returns the entry's previous contents,
// so a single address serves as both the read and the write slot.
module line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 258
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Streams raster pixels through two line buffers and a 3x3 shift register,
// emitting one registered window per interior pixel of each frame.
module window_3x3_gen
    import win_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 258,
    parameter int IMG_H  = 34
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_sof,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIN_N*DATA_W-1:0]   out_win,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_eof,
    output logic                      err_sof
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_col, w_col, w_col_nxt;
    logic [RW-1:0]     r_row, w_row, w_row_nxt;
    logic [DATA_W-1:0] r_win [WIN_N];
    logic [DATA_W-1:0] w_lb0_rd, w_lb1_rd;
    logic              r_out_valid, r_sof, r_eol, r_eof, r_err_sof;
    logic              w_in_fire, w_in_frame, w_eol, w_last, w_complete;

    assign in_ready  = out_ready || !r_out_valid;
    assign w_in_fire = in_valid && in_ready;

    // A start-of-frame pixel always lands at (0,0), whatever the counters hold.
    assign w_in_frame = in_sof || (r_state == ST_FILL) || (r_state == ST_RUN);
    assign w_col      = in_sof ? '0 : r_col;
    assign w_row      = in_sof ? '0 : r_row;
    assign w_eol      = (w_col == COL_LAST);
    assign w_last     = w_eol && (w_row == ROW_LAST);
    assign w_complete = w_in_frame && (w_row >= RW'(2)) && (w_col >= CW'(2));

    always_comb begin
        w_col_nxt = w_eol ? '0 : w_col + CW'(1);
        w_row_nxt = w_row;
        if (w_eol) begin
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_DONE) begin
            w_state_nxt = ST_IDLE;
        end
        if (w_in_fire && w_in_frame) begin
            if (w_last) begin
                w_state_nxt = ST_DONE;
            end else if (w_complete && !w_eol) begin
                w_state_nxt = ST_RUN;
            end else begin
                w_state_nxt = ST_FILL;
            end
        end
    end

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_prev1 (
        .clk     (clk),
        .i_we    (w_in_fire && w_in_frame),
        .i_addr  (w_col),
        .i_wdata (in_data),
        .o_rdata (w_lb0_rd)
    );

    line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_prev2 (
        .clk     (clk),
        .i_we    (w_in_fire && w_in_frame),
        .i_addr  (w_col),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    // The shift register doubles as the output register: it only moves on an
    // accepted pixel, which cannot happen while a window is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_err_sof   <= 1'b0;
            for (int i = 0; i < WIN_N; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_err_sof <= w_in_fire && in_sof &&
                         ((r_state == ST_FILL) || (r_state == ST_RUN));
            if (w_in_fire && w_in_frame) begin
                r_col       <= w_col_nxt;
                r_row       <= w_row_nxt;
                r_win[W_TL] <= r_win[W_TM];
                r_win[W_TM] <= r_win[W_TR];
                r_win[W_TR] <= w_lb1_rd;
                r_win[W_ML] <= r_win[W_MM];
                r_win[W_MM] <= r_win[W_MR];
                r_win[W_MR] <= w_lb0_rd;
                r_win[W_BL] <= r_win[W_BM];
                r_win[W_BM] <= r_win[W_BR];
                r_win[W_BR] <= in_data;
            end
            if (w_in_fire && w_complete) begin
                r_out_valid <= 1'b1;
                r_sof       <= (w_row == RW'(2)) && (w_col == CW'(2));
                r_eol       <= w_eol;
                r_eof       <= w_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < WIN_N; g++) begin : g_pack
        assign out_win[g*DATA_W +: DATA_W] = r_win[g];
    end

    assign out_valid = r_out_valid;
    assign out_sof   = r_sof;
    assign out_eol   = r_eol;
    assign out_eof   = r_eof;
    assign err_sof   = r_err_sof;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomized bench for window_3x3_gen: a frame-buffer reference model predicts
// every window and flag; a tiny 3x3 instance covers the minimal image size.
module tb_window_3x3_gen;

    localparam int W    = 258;
    localparam int H    = 34;
    localparam int NWIN = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_sof, out_ready;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, out_sof, out_eol, out_eof, err_sof;
    logic [71:0] out_win;

    logic        s_in_valid, s_in_sof, s_out_ready;
    logic [7:0]  s_in_data;
    logic        s_in_ready, s_out_valid, s_out_sof, s_out_eol, s_out_eof, s_err_sof;
    logic [71:0] s_out_win;

    int          n_chk = 0, n_pass = 0;
    logic [74:0] exp_q [$];
    logic [7:0]  fb [W*H];
    int          m_k = 0;
    bit          m_active = 1'b0;
    int          exp_err = 0, obs_err = 0, n_win = 0, last_sof_idx = -1;
    logic [71:0] first_win = '0;
    bit          held = 1'b0;
    logic [74:0] held_val = '0;
    bit          rnd_in = 1'b0, rnd_out = 1'b0;
    int          s_cnt = 0;
    logic [71:0] s_win = '0;
    logic [2:0]  s_flags = '0;
    bit          s_err_seen = 1'b0;

    always #5 clk = ~clk;

    window_3x3_gen #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sof(in_sof), .out_valid(out_valid),
        .out_ready(out_ready), .out_win(out_win), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .err_sof(err_sof)
    );

    window_3x3_gen #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_sof(s_in_sof), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_win(s_out_win), .out_sof(s_out_sof),
        .out_eol(s_out_eol), .out_eof(s_out_eof), .err_sof(s_err_sof)
    );

    task automatic check_val(input string tag, input logic [74:0] got, input logic [74:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    // Reference: position is the count of accepted pixels since the last
    // start-of-frame; windows come straight from the stored frame.
    function automatic void model_push(input logic [7:0] d, input bit sof);
        int r, c;
        logic [71:0] win;
        if (sof) begin
            if (m_active && m_k < W*H) exp_err++;
            m_active = 1'b1;
            m_k = 0;
        end
        if (!m_active || m_k >= W*H) return;
        fb[m_k] = d;
        r = m_k / W;
        c = m_k % W;
        if (r >= 2 && c >= 2) begin
            for (int i = 0; i < 9; i++)
                win[i*8 +: 8] = fb[(r - 2 + i / 3) * W + (c - 2 + i % 3)];
            exp_q.push_back({(r == 2 && c == 2), (c == W - 1), (r == H - 1 && c == W - 1), win});
        end
        m_k++;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [74:0] e;
        if (rst_n) begin
            if (held)
                check_val("stall_hold", {out_valid, out_sof, out_eol, out_eof, out_win},
                          {1'b1, held_val});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_win", 75'(1), 75'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_val("win", {3'b0, out_win}, {3'b0, e[71:0]});
                    check_val("flags", {72'b0, out_sof, out_eol, out_eof}, {72'b0, e[74:72]});
                end
                if (n_win == 0) first_win = out_win;
                if (out_sof) last_sof_idx = n_win;
                n_win++;
            end
            held     = out_valid && !out_ready;
            held_val = {out_sof, out_eol, out_eof, out_win};
            if (err_sof) obs_err++;
        end else begin
            held = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (s_out_valid && s_out_ready) begin
            s_cnt++;
            s_win   = s_out_win;
            s_flags = {s_out_sof, s_out_eol, s_out_eof};
        end
        if (s_err_sof) s_err_seen = 1'b1;
    end

    task automatic send_pixel(input logic [7:0] d, input bit sof);
        int t;
        if (rnd_in) begin
            while ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 2000) begin
                check_val("in_timeout", 75'(1), 75'(0));
                finish_run();
            end
        end
        model_push(d, sof);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input bit rnd_data, input int npix, input bit with_sof);
        for (int k = 0; k < npix; k++)
            send_pixel(rnd_data ? 8'($urandom) : 8'(k % 256), with_sof && k == 0);
    endtask

    task automatic start_test();
        n_win = 0;
        exp_err = 0;
        obs_err = 0;
        last_sof_idx = -1;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_drain"}, 75'(exp_q.size()), 75'(0));
        check_val({tag, "_err_cnt"}, 75'(obs_err), 75'(exp_err));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        s_in_valid = 1'b0; s_in_sof = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", 75'(out_valid), 75'(0));
        check_val("rst_out_win", {3'b0, out_win}, 75'(0));
        check_val("rst_flags", 75'({out_sof, out_eol, out_eof, err_sof}), 75'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_in_ready", 75'(in_ready), 75'(1));

        // minimal 3x3 image
        for (int i = 0; i < 9; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = 8'(i + 1);
            s_in_sof   = (i == 0);
            @(negedge clk);
            check_val("tiny_ready", 75'(s_in_ready), 75'(1));
            @(posedge clk);
            #1;
        end
        s_in_valid = 1'b0;
        s_in_sof   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("tiny_count", 75'(s_cnt), 75'(1));
        check_val("tiny_win", {3'b0, s_win}, {3'b0, 72'h09_08_07_06_05_04_03_02_01});
        check_val("tiny_flags", 75'(s_flags), 75'(3'b111));
        check_val("tiny_err", 75'(s_err_seen), 75'(0));

        // continuous ramp frame
        start_test();
        send_frame(1'b0, W*H, 1'b1);
        drain("ramp");
        check_val("ramp_count", 75'(n_win), 75'(NWIN));
        check_val("ramp_first", {3'b0, first_win}, {3'b0, 72'h06_05_04_04_03_02_02_01_00});

        // ramp frame with input gaps and output back-pressure
        start_test();
        rnd_in = 1'b1;
        rnd_out = 1'b1;
        send_frame(1'b0, W*H, 1'b1);
        drain("stall");
        rnd_in = 1'b0;
        rnd_out = 1'b0;
        check_val("stall_count", 75'(n_win), 75'(NWIN));
        check_val("stall_first", {3'b0, first_win}, {3'b0, 72'h06_05_04_04_03_02_02_01_00});

        // new frame starts at pixel (5,10) of the current one
        start_test();
        send_frame(1'b1, 5*W + 10, 1'b1);
        send_frame(1'b1, W*H, 1'b1);
        drain("resof");
        check_val("resof_err", 75'(obs_err), 75'(1));
        check_val("resof_count", 75'(n_win), 75'(3*(W-2) + 8 + NWIN));

        // reset mid-frame at pixel (10,100)
        start_test();
        send_frame(1'b1, 10*W + 100, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("midrst_out_valid", 75'(out_valid), 75'(0));
        exp_q.delete();
        m_active = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("midrst_in_ready", 75'(in_ready), 75'(1));
        n_win = 0;
        send_frame(1'b1, 300, 1'b0);
        check_val("midrst_discard", 75'(n_win), 75'(0));
        send_frame(1'b1, W*H, 1'b1);
        drain("midrst");
        check_val("midrst_count", 75'(n_win), 75'(NWIN));

        // two frames back to back
        start_test();
        send_frame(1'b1, W*H, 1'b1);
        send_frame(1'b1, W*H, 1'b1);
        drain("b2b");
        check_val("b2b_count", 75'(n_win), 75'(2*NWIN));
        check_val("b2b_err", 75'(obs_err), 75'(0));
        check_val("b2b_sof_idx", 75'(last_sof_idx), 75'(NWIN));

        finish_run();
    end

endmodule
